// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: op codes, the "no producer" tag and the
// reservation-station entry layout used by the mult/add stations and the
// register status table.
package tomasulo_pkg;

   localparam int unsigned RS_DATA_W = 16;
   localparam int unsigned RS_TAG_W  = 3;
   localparam int unsigned RS_OP_W   = 1;

   localparam logic [RS_OP_W-1:0]  OP_MUL   = 1'b0;
   localparam logic [RS_OP_W-1:0]  OP_DIV   = 1'b1;
   localparam logic [RS_TAG_W-1:0] TAG_NONE = 3'd0;

   typedef struct packed {
      logic                 busy;
      logic [RS_OP_W-1:0]   op;
      logic [RS_DATA_W-1:0] vj;
      logic [RS_DATA_W-1:0] vk;
      logic [RS_TAG_W-1:0]  qj;
      logic [RS_TAG_W-1:0]  qk;
   } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Dispatch selector: ready vector -> one-hot grant + index.
// Default: lowest-index ready entry wins.
// RS_AGE_ORDER_EN: the ready entry with the smallest age rank (oldest) wins.
module rs_select #(
   parameter int NUM_ENTRIES = 3,
   parameter int IDX_W       = 2
`ifdef RS_AGE_ORDER_EN
   , parameter int AGE_W     = 2
`endif
) (
`ifdef RS_AGE_ORDER_EN
   input  logic [NUM_ENTRIES*AGE_W-1:0] age,
`endif
   input  logic [NUM_ENTRIES-1:0]       ready,
   output logic [NUM_ENTRIES-1:0]       grant,
   output logic [IDX_W-1:0]             grant_idx,
   output logic                         any_ready
);

`ifdef RS_AGE_ORDER_EN
   logic [AGE_W-1:0] best_age_s;
`endif

   // Priority scan over the ready set; the first qualifying entry (or the oldest) wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_ready = 1'b0;
`ifdef RS_AGE_ORDER_EN
      best_age_s = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (ready[i] && (!any_ready || (age[i*AGE_W +: AGE_W] < best_age_s))) begin
            grant      = '0;
            grant[i]   = 1'b1;
            grant_idx  = IDX_W'(i);
            any_ready  = 1'b1;
            best_age_s = age[i*AGE_W +: AGE_W];
         end else begin
            best_age_s = best_age_s;
         end
      end
`else
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (ready[i] && !any_ready) begin
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
            any_ready = 1'b1;
         end else begin
            any_ready = any_ready;
         end
      end
`endif
   end

endmodule

// File: rtl/mult_reservation_station.sv
// Reservation station for the multiply/divide unit. Holds issued ops with
// operand values or producer tags, snoops the CDB, dispatches one ready op
// per cycle. Optional macro RS_AGE_ORDER_EN selects oldest-ready dispatch.
module mult_reservation_station
   import tomasulo_pkg::*;
#(
   parameter int NUM_ENTRIES = 3,
   parameter int DATA_W      = RS_DATA_W,
   parameter int TAG_W       = RS_TAG_W,
   parameter int OP_W        = RS_OP_W,
   parameter int TAG_BASE    = 1
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   issue_valid,
   output logic                   issue_ready,
   input  logic [OP_W-1:0]        issue_op,
   input  logic [DATA_W-1:0]      issue_vj,
   input  logic [DATA_W-1:0]      issue_vk,
   input  logic [TAG_W-1:0]       issue_qj,
   input  logic [TAG_W-1:0]       issue_qk,
   output logic [TAG_W-1:0]       issue_tag,
   input  logic                   cdb_valid,
   input  logic [TAG_W-1:0]       cdb_tag,
   input  logic [DATA_W-1:0]      cdb_data,
   output logic                   disp_valid,
   input  logic                   disp_ready,
   output logic [OP_W-1:0]        disp_op,
   output logic [DATA_W-1:0]      disp_vj,
   output logic [DATA_W-1:0]      disp_vk,
   output logic [TAG_W-1:0]       disp_tag,
   output logic [NUM_ENTRIES-1:0] busy
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

   logic [NUM_ENTRIES-1:0] busy_r;
   logic [OP_W-1:0]        op_r [NUM_ENTRIES];
   logic [DATA_W-1:0]      vj_r [NUM_ENTRIES];
   logic [DATA_W-1:0]      vk_r [NUM_ENTRIES];
   logic [TAG_W-1:0]       qj_r [NUM_ENTRIES];
   logic [TAG_W-1:0]       qk_r [NUM_ENTRIES];

   logic [IDX_W-1:0]       free_idx_s;
   logic [NUM_ENTRIES-1:0] ready_s, grant_s, sel_oh_s, hold_oh_r;
   logic [IDX_W-1:0]       grant_idx_s, sel_idx_s, hold_idx_r;
   logic                   any_ready_s, hold_r, issue_fire_s, disp_fire_s;
   logic                   cdb_hit_j_s, cdb_hit_k_s;

   // Lowest free slot; scanning downward lets the lowest index win.
   always_comb begin
      free_idx_s = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!busy_r[i]) begin
            free_idx_s = IDX_W'(i);
         end else begin
            free_idx_s = free_idx_s;
         end
      end
   end

   // Ready set from registered state only: busy with both operands present.
   always_comb begin
      ready_s = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ready_s[i] = busy_r[i] & (qj_r[i] == NO_TAG) & (qk_r[i] == NO_TAG);
      end
   end

   assign issue_ready  = ~&busy_r;
   assign issue_tag    = TAG_W'(TAG_BASE) + TAG_W'(free_idx_s);
   assign issue_fire_s = issue_valid & issue_ready;
   // Operand arriving on the CDB in the same cycle it is issued.
   assign cdb_hit_j_s  = cdb_valid & (issue_qj != NO_TAG) & (issue_qj == cdb_tag);
   assign cdb_hit_k_s  = cdb_valid & (issue_qk != NO_TAG) & (issue_qk == cdb_tag);

`ifdef RS_AGE_ORDER_EN
   localparam int AGE_W = IDX_W;
   localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

   logic [AGE_W-1:0]             age_r [NUM_ENTRIES];
   logic [NUM_ENTRIES*AGE_W-1:0] age_flat_s;
   logic [CNT_W-1:0]             busy_cnt_s;
   logic [AGE_W-1:0]             new_rank_s, sel_age_s;

   // Flatten ranks for the selector and count occupied slots for the new rank.
   always_comb begin
      age_flat_s = '0;
      busy_cnt_s = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         age_flat_s[i*AGE_W +: AGE_W] = age_r[i];
         busy_cnt_s = busy_cnt_s + CNT_W'(busy_r[i]);
      end
   end

   // A dispatch on the same edge shifts everyone above it down, including the newcomer.
   assign new_rank_s = AGE_W'(busy_cnt_s - CNT_W'(disp_fire_s));
   assign sel_age_s  = age_r[sel_idx_s];

   // Age ranks: new entry goes to the back, dispatch closes the gap.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) age_r[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issue_fire_s && (free_idx_s == IDX_W'(i))) begin
               age_r[i] <= new_rank_s;
            end else if (disp_fire_s && busy_r[i] && (age_r[i] > sel_age_s)) begin
               age_r[i] <= age_r[i] - AGE_W'(1);
            end else begin
               age_r[i] <= age_r[i];
            end
         end
      end
   end

   rs_select #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .AGE_W(AGE_W)) u_select (
      .age       (age_flat_s),
      .ready     (ready_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any_ready (any_ready_s)
   );
`else
   rs_select #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_select (
      .ready     (ready_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any_ready (any_ready_s)
   );
`endif

   // A stalled offer is pinned so disp_* cannot change until the FU accepts it.
   assign sel_idx_s   = hold_r ? hold_idx_r : grant_idx_s;
   assign sel_oh_s    = hold_r ? hold_oh_r  : grant_s;
   assign disp_valid  = hold_r | any_ready_s;
   assign disp_fire_s = disp_valid & disp_ready;
   assign disp_op     = op_r[sel_idx_s];
   assign disp_vj     = vj_r[sel_idx_s];
   assign disp_vk     = vk_r[sel_idx_s];
   assign disp_tag    = TAG_W'(TAG_BASE) + TAG_W'(sel_idx_s);
   assign busy        = busy_r;

   // Remember the offered entry while the FU back-pressures.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hold_r     <= 1'b0;
         hold_idx_r <= '0;
         hold_oh_r  <= '0;
      end else begin
         hold_r     <= disp_valid & ~disp_ready;
         hold_idx_r <= sel_idx_s;
         hold_oh_r  <= sel_oh_s;
      end
   end

   // Entry state: issue write, dispatch release and CDB operand capture.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         busy_r <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            op_r[i] <= OP_W'(OP_MUL);
            vj_r[i] <= '0;
            vk_r[i] <= '0;
            qj_r[i] <= NO_TAG;
            qk_r[i] <= NO_TAG;
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (issue_fire_s && (free_idx_s == IDX_W'(i))) begin
               busy_r[i] <= 1'b1;
               op_r[i]   <= issue_op;
               vj_r[i]   <= cdb_hit_j_s ? cdb_data : issue_vj;
               qj_r[i]   <= cdb_hit_j_s ? NO_TAG   : issue_qj;
               vk_r[i]   <= cdb_hit_k_s ? cdb_data : issue_vk;
               qk_r[i]   <= cdb_hit_k_s ? NO_TAG   : issue_qk;
            end else begin
               busy_r[i] <= (disp_fire_s && sel_oh_s[i]) ? 1'b0 : busy_r[i];
               op_r[i]   <= op_r[i];
               if (busy_r[i] && cdb_valid && (qj_r[i] != NO_TAG) && (qj_r[i] == cdb_tag)) begin
                  vj_r[i] <= cdb_data;
                  qj_r[i] <= NO_TAG;
               end else begin
                  vj_r[i] <= vj_r[i];
                  qj_r[i] <= qj_r[i];
               end
               if (busy_r[i] && cdb_valid && (qk_r[i] != NO_TAG) && (qk_r[i] == cdb_tag)) begin
                  vk_r[i] <= cdb_data;
                  qk_r[i] <= NO_TAG;
               end else begin
                  vk_r[i] <= vk_r[i];
                  qk_r[i] <= qk_r[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_reservation_station.sv
// Bench for mult_reservation_station: table-driven issue vectors plus
// hand-written CDB/stall/reset sequences; dispatches are checked against a
// scoreboard queue filled when stimulus is driven.
module tb_mult_reservation_station;
   import tomasulo_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        issue_valid, issue_ready;
   logic [0:0]  issue_op;
   logic [15:0] issue_vj, issue_vk;
   logic [2:0]  issue_qj, issue_qk, issue_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        disp_valid, disp_ready;
   logic [0:0]  disp_op;
   logic [15:0] disp_vj, disp_vk;
   logic [2:0]  disp_tag;
   logic [2:0]  busy;

   typedef struct packed {
      logic [0:0]  op;
      logic [15:0] vj;
      logic [15:0] vk;
      logic [2:0]  tag;
   } exp_t;

   typedef struct {
      logic [0:0]  op;
      logic [15:0] vj;
      logic [15:0] vk;
      logic [2:0]  tag;
   } vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[6];
   int   n_cmp = 0;
   int   n_bad = 0;

   mult_reservation_station dut (
      .Clock(Clock), .Reset(Reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
      .issue_tag(issue_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
      .busy(busy)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted dispatch must match the oldest expected record.
   always @(negedge Clock) begin
      if (!Reset && disp_valid && disp_ready) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL disp_unexpected: got tag %0d, expected no dispatch", disp_tag);
         end else begin
            mon_e = sb_q.pop_front();
            if ({disp_op, disp_vj, disp_vk, disp_tag} !== mon_e) begin
               n_bad++;
               $display("FAIL disp_data: got op=%0h vj=%0h vk=%0h tag=%0d, expected op=%0h vj=%0h vk=%0h tag=%0d",
                        disp_op, disp_vj, disp_vk, disp_tag, mon_e.op, mon_e.vj, mon_e.vk, mon_e.tag);
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic issue_drv(input logic [0:0] op, input logic [15:0] vj, input logic [15:0] vk,
                            input logic [2:0] qj, input logic [2:0] qk);
      issue_valid = 1'b1;
      issue_op    = op;
      issue_vj    = vj;
      issue_vk    = vk;
      issue_qj    = qj;
      issue_qk    = qk;
   endtask

   task automatic cdb_drv(input logic [2:0] tag, input logic [15:0] data);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_data  = data;
   endtask

   task automatic drain(input string name, input int budget);
      int c = 0;
      while (sb_q.size() != 0 && c < budget) begin
         tick();
         c++;
      end
      chk(name, sb_q.size(), 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 16'h0001, 16'h0002, 3'd1};
      vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 3'd2};
      vecs[2] = '{1'b0, 16'h0000, 16'hFFFF, 3'd1};
      vecs[3] = '{1'b1, 16'h8000, 16'h7FFF, 3'd2};
      vecs[4] = '{1'b0, 16'hA5A5, 16'h5A5A, 3'd1};
      vecs[5] = '{1'b1, 16'h1234, 16'h0000, 3'd2};

      Reset = 1'b1; issue_valid = 1'b0; issue_op = 1'b0;
      issue_vj = 16'h0; issue_vk = 16'h0; issue_qj = 3'd0; issue_qk = 3'd0;
      cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'h0; disp_ready = 1'b0;
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock);
      chk("reset_busy", busy, 32'd0);
      chk("reset_disp_valid", disp_valid, 32'd0);
      chk("reset_issue_ready", issue_ready, 32'd1);
      chk("reset_issue_tag", issue_tag, 32'd1);

      // Both operands ready: dispatchable one cycle after issue.
      tick();
      issue_drv(OP_MUL, 16'd3, 16'd5, 3'd0, 3'd0);
      sb_q.push_back('{1'b0, 16'd3, 16'd5, 3'd1});
      @(negedge Clock);
      chk("lat_issue_tag", issue_tag, 32'd1);
      chk("lat_disp_valid_before", disp_valid, 32'd0);
      tick();
      issue_valid = 1'b0;
      @(negedge Clock);
      chk("lat_disp_valid", disp_valid, 32'd1);
      chk("lat_disp_vj", disp_vj, 32'd3);
      chk("lat_disp_vk", disp_vk, 32'd5);
      chk("lat_disp_tag", disp_tag, 32'd1);
      tick();
      disp_ready = 1'b1;

      // Back-to-back ready issues: tags alternate as slot 0 frees every other cycle.
      for (int k = 0; k < 6; k++) begin
         tick();
         issue_drv(vecs[k].op, vecs[k].vj, vecs[k].vk, 3'd0, 3'd0);
         sb_q.push_back('{vecs[k].op, vecs[k].vj, vecs[k].vk, vecs[k].tag});
         @(negedge Clock);
         chk("tbl_issue_tag", issue_tag, 32'(vecs[k].tag));
      end
      tick();
      issue_valid = 1'b0;
      drain("tbl_drain", 20);

      // Pending qj resolved by a later CDB broadcast.
      issue_drv(OP_DIV, 16'hDEAD, 16'd7, 3'd4, 3'd0);
      sb_q.push_back('{1'b1, 16'd9, 16'd7, 3'd1});
      @(negedge Clock);
      chk("snoop_issue_tag", issue_tag, 32'd1);
      tick();
      issue_valid = 1'b0;
      cdb_drv(3'd4, 16'd9);
      @(negedge Clock);
      chk("snoop_wait", disp_valid, 32'd0);
      tick();
      cdb_valid = 1'b0;
      @(negedge Clock);
      chk("snoop_ready", disp_valid, 32'd1);
      tick();

      // Operand arriving on the CDB in the issue cycle.
      issue_drv(OP_MUL, 16'd2, 16'h1111, 3'd0, 3'd5);
      cdb_drv(3'd5, 16'h00FF);
      sb_q.push_back('{1'b0, 16'd2, 16'h00FF, 3'd1});
      @(negedge Clock);
      chk("coll_issue_tag", issue_tag, 32'd1);
      tick();
      issue_valid = 1'b0;
      cdb_valid = 1'b0;
      @(negedge Clock);
      chk("coll_disp_valid", disp_valid, 32'd1);
      tick();

      // Fill, drop when full, stall stability, release.
      disp_ready = 1'b0;
      issue_drv(OP_MUL, 16'h0, 16'h0022, 3'd4, 3'd0);
      @(negedge Clock);
      chk("fill_tag0", issue_tag, 32'd1);
      tick();
      issue_drv(OP_DIV, 16'h0, 16'h0011, 3'd5, 3'd0);
      @(negedge Clock);
      chk("fill_tag1", issue_tag, 32'd2);
      tick();
      issue_drv(OP_MUL, 16'h0, 16'h0033, 3'd6, 3'd0);
      @(negedge Clock);
      chk("fill_tag2", issue_tag, 32'd3);
      tick();
      issue_drv(OP_DIV, 16'h0001, 16'h0001, 3'd0, 3'd0);
      @(negedge Clock);
      chk("full_issue_ready", issue_ready, 32'd0);
      chk("full_busy", busy, 32'd7);
      tick();
      issue_valid = 1'b0;
      @(negedge Clock);
      chk("full_drop_no_disp", disp_valid, 32'd0);
      chk("full_drop_busy", busy, 32'd7);
      tick();
      cdb_drv(3'd5, 16'h1234);
      sb_q.push_back('{1'b1, 16'h1234, 16'h0011, 3'd2});
      tick();
      cdb_drv(3'd4, 16'h0AAA);
      sb_q.push_back('{1'b0, 16'h0AAA, 16'h0022, 3'd1});
      @(negedge Clock);
      chk("stall_valid", disp_valid, 32'd1);
      chk("stall_tag_a", disp_tag, 32'd2);
      tick();
      cdb_valid = 1'b0;
      @(negedge Clock);
      chk("stall_tag_b", disp_tag, 32'd2);
      chk("stall_vj_b", disp_vj, 32'h1234);
      tick();
      @(negedge Clock);
      chk("stall_tag_c", disp_tag, 32'd2);
      tick();
      disp_ready = 1'b1;
      @(negedge Clock);
      chk("stall_still_full", issue_ready, 32'd0);
      tick();
      @(negedge Clock);
      chk("release_issue_ready", issue_ready, 32'd1);
      chk("release_busy", busy, 32'd5);
      tick();
      cdb_drv(3'd6, 16'h5555);
      sb_q.push_back('{1'b0, 16'h5555, 16'h0033, 3'd3});
      tick();
      cdb_valid = 1'b0;
      drain("fill_drain", 20);

      // Ordering: entry 2 (older) and entry 0 (reissued) become ready together.
      issue_drv(OP_MUL, 16'h0, 16'h0101, 3'd7, 3'd0);
      tick();
      issue_drv(OP_MUL, 16'h0, 16'h0202, 3'd5, 3'd0);
      tick();
      issue_drv(OP_MUL, 16'h0, 16'h0303, 3'd6, 3'd0);
      tick();
      issue_valid = 1'b0;
      cdb_drv(3'd7, 16'h0A0A);
      sb_q.push_back('{1'b0, 16'h0A0A, 16'h0101, 3'd1});
      tick();
      cdb_valid = 1'b0;
      tick();
      issue_drv(OP_DIV, 16'h0D0D, 16'h0E0E, 3'd0, 3'd0);
      cdb_drv(3'd6, 16'h0C0C);
`ifdef RS_AGE_ORDER_EN
      sb_q.push_back('{1'b0, 16'h0C0C, 16'h0303, 3'd3});
      sb_q.push_back('{1'b1, 16'h0D0D, 16'h0E0E, 3'd1});
`else
      sb_q.push_back('{1'b1, 16'h0D0D, 16'h0E0E, 3'd1});
      sb_q.push_back('{1'b0, 16'h0C0C, 16'h0303, 3'd3});
`endif
      @(negedge Clock);
      chk("order_issue_tag", issue_tag, 32'd1);
      tick();
      issue_valid = 1'b0;
      cdb_valid = 1'b0;
      @(negedge Clock);
`ifdef RS_AGE_ORDER_EN
      chk("order_first_tag", disp_tag, 32'd3);
`else
      chk("order_first_tag", disp_tag, 32'd1);
`endif
      tick();
      cdb_drv(3'd5, 16'h0B0B);
      sb_q.push_back('{1'b0, 16'h0B0B, 16'h0202, 3'd2});
      tick();
      cdb_valid = 1'b0;
      drain("order_drain", 20);

      // Asynchronous reset with two busy, waiting entries.
      issue_drv(OP_MUL, 16'h0, 16'h0044, 3'd4, 3'd0);
      tick();
      issue_drv(OP_MUL, 16'h0, 16'h0055, 3'd5, 3'd0);
      tick();
      issue_valid = 1'b0;
      @(negedge Clock);
      chk("prerst_busy", busy, 32'd3);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_busy", busy, 32'd0);
      chk("async_rst_disp_valid", disp_valid, 32'd0);
      chk("async_rst_issue_ready", issue_ready, 32'd1);
      tick();
      tick();
      Reset = 1'b0;
      issue_drv(OP_DIV, 16'h7777, 16'h8888, 3'd0, 3'd0);
      cdb_drv(3'd4, 16'h9999);
      sb_q.push_back('{1'b1, 16'h7777, 16'h8888, 3'd1});
      tick();
      issue_valid = 1'b0;
      cdb_valid = 1'b0;
      drain("post_rst_drain", 20);
      @(negedge Clock);
      chk("post_rst_busy", busy, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
